// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters, with bounded bursts.
// Define FIFO_ARB_STALL_CNT_EN to add a saturating 16-bit back-pressure stall counter output.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      fifo_full,
    output logic                      fifo_write_en,
    output logic [DATA_W-1:0]         fifo_data_in,
    output logic                      busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic [IDX_W-1:0]   owner_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;

    logic [IDX_W-1:0]   owner_d;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic               any_req;
    logic               owner_req;
    logic               xfer;
    logic               last_beat;
    logic               burst_end;
    logic [DATA_W-1:0]  owner_data;

    // NOTE: every combinational output is given a default before the loop, so no latch can form.
    always_comb begin : pick_next_owner
        int idx;
        owner_d = rr_ptr_q;
        any_req = 1'b0;
        // Walk from the farthest offset down so the nearest requester at/after rr_ptr wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req[idx]) begin
                owner_d = IDX_W'(idx);
                any_req = 1'b1;
            end
        end
    end

    assign owner_req  = req[owner_q];
    assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
    assign xfer       = (state_q == GRANT) && owner_req && !fifo_full;
    assign last_beat  = req_last[owner_q] || (int'(beat_cnt_q) + 1 == BURST_MAX);
    assign burst_end  = (state_q == GRANT) && ((xfer && last_beat) || !owner_req);
    assign rr_ptr_d   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + IDX_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: reset is synchronous and returns every control register to a clean idle state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= GRANT;
                        busy_q     <= 1'b1;
                        owner_q    <= owner_d;
                        gnt_q      <= NUM_REQ'(1) << owner_d;
                        beat_cnt_q <= '0;
                    end
                end
                GRANT: begin
                    if (burst_end) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        gnt_q    <= '0;
                        rr_ptr_q <= rr_ptr_d;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write strobe and data are forced low while reset is held, even mid-burst.
    assign fifo_write_en = xfer && !rst;
    assign fifo_data_in  = ((state_q == GRANT) && !rst) ? owner_data : '0;
    assign gnt           = gnt_q;
    assign busy          = busy_q;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if ((state_q == GRANT) && owner_req && fifo_full && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the linear FIFO among NUM_REQ requesters.
- Grants one requester at a time for a burst of up to BURST_MAX beats.
- Honours FIFO full back-pressure and muxes the owner's data onto the FIFO write interface.
- Sits directly in front of the FIFO write port; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, data width, matching the FIFO data_in width
- BURST_MAX, 4, maximum beats per grant before forced rotation (1..15)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- req  input  NUM_REQ  per-requester write request; held high while data is pending
- req_data  input  NUM_REQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  input  NUM_REQ  marks the final beat of requester i's burst
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle
- fifo_full  input  1  FIFO full flag
- fifo_write_en  output  1  write strobe to the FIFO
- fifo_data_in  output  DATA_W  data to the FIFO
- busy  output  1  high while in the GRANT state

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE, gnt=0, busy=0, rr_ptr=0, beat_cnt=0.
  - fifo_write_en=0 and fifo_data_in=0 while rst is high.
- States:
  - IDLE: if any req is high, select the first requester at or after rr_ptr, searching upward modulo NUM_REQ. Next cycle: gnt=onehot(sel), state=GRANT, beat_cnt=0. Grant latency from req to gnt is one cycle.
  - GRANT, owner o: a beat transfers in a cycle iff gnt[o] && req[o] && !fifo_full.
- Transfer cycle outputs (combinational):
  - fifo_write_en=1 and fifo_data_in=req_data[o].
  - Otherwise fifo_write_en=0 and fifo_data_in holds the owner's data, or 0 when idle.
  - Each transfer increments beat_cnt.
- Burst end, evaluated at the clock edge:
  - Transfer with req_last[o]=1.
  - Transfer with beat_cnt+1==BURST_MAX.
  - req[o]=0 with no transfer (requester withdrew).
  - On burst end: rr_ptr=(o+1) mod NUM_REQ, gnt=0, state=IDLE. There is one idle turnaround cycle between grants.
- fifo_full=1 in GRANT:
  - No transfer; owner keeps the grant; beat_cnt is unchanged.
  - A stall never forces rotation.
- Non-owner requests are ignored while in GRANT, with no pre-emption.
- Simultaneous requests in IDLE are resolved purely by the round-robin order from rr_ptr. Starvation is impossible: every requester is served within NUM_REQ grants.
- Requester protocol: req_data must be stable while req is high and the requester is ungranted. Requesters sample gnt[i] together with !fifo_full to know a beat was accepted.
- Reset asserted mid-burst: the burst is abandoned immediately. There are no partial-state remnants, and the next grant starts from requester 0.
- The FIFO's internal pointer wrap is not visible to this block; only fifo_full matters.

Optional Feature:
- Macro: FIFO_ARB_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, width 16.
  - stall_cnt increments every cycle with state=GRANT, req[owner]=1 and fifo_full=1.
  - It saturates at 16'hFFFF and is cleared only by rst.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Single requester: req[0]=1, 3 beats 0x1,0x2,0x3 with req_last on the third, fifo_full=0 -> gnt=4'b0001 one cycle after req, three fifo_write_en pulses with matching data, then gnt=0 and rr_ptr=1.
- All four requesting continuously, req_last never set, BURST_MAX=4 -> grants rotate 0,1,2,3,0; each grant yields exactly 4 writes; one idle cycle between grants.
- Back-pressure: owner 2 mid-burst, fifo_full=1 for 5 cycles -> fifo_write_en=0, gnt stays 4'b0100, beat count is preserved, burst completes after full drops. With FIFO_ARB_STALL_CNT_EN defined, stall_cnt=5.
- Withdrawal: owner 1 drops req after 1 beat with no req_last -> grant released next edge, next grant goes to requester 2 if requesting.
- Reset mid-burst: rst=1 during owner 3's second beat -> next cycle gnt=0, busy=0, fifo_write_en=0. Afterwards, with req=4'b1010, the first grant goes to requester 1.
